// File: rtl/perceptron_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// perceptron_seq_ctrl_if
//
// Bundles the feature-token input stream and the classification result
// stream of the perceptron sequencing controller.
//
//   feat_valid  : feature token present                  (master -> slave)
//   feat_ready  : controller accepts token                (slave  -> master)
//   feat_kind   : 00 edge, 01 curve, 10 marker, 11 rsvd   (master -> slave)
//   feat_last   : token closes the frame                  (master -> slave)
//   class_valid : result present                          (slave  -> master)
//   class_ready : consumer takes result                   (master -> slave)
//   class_digit : matched digit 0-9, 4'hF on miss         (slave  -> master)
//   class_hit   : 1 = table match, 0 = miss               (slave  -> master)
//   sum_out     : weighted sum of the frame               (slave  -> master)
//   overflow    : a counter saturated during the frame    (slave  -> master)
//   busy        : controller is not collecting tokens     (slave  -> master)
//
// The slave modport is the controller's view; the master modport is the
// view of the surrounding logic (feature extractor plus output consumer).
//------------------------------------------------------------------------------
interface perceptron_seq_ctrl_if #(
   parameter int SUM_W = 8
);
   logic             feat_valid;
   logic             feat_ready;
   logic [1:0]       feat_kind;
   logic             feat_last;
   logic             class_valid;
   logic             class_ready;
   logic [3:0]       class_digit;
   logic             class_hit;
   logic [SUM_W-1:0] sum_out;
   logic             overflow;
   logic             busy;

   modport master (
      output feat_valid, feat_kind, feat_last, class_ready,
      input  feat_ready, class_valid, class_digit, class_hit, sum_out,
             overflow, busy
   );

   modport slave (
      input  feat_valid, feat_kind, feat_last, class_ready,
      output feat_ready, class_valid, class_digit, class_hit, sum_out,
             overflow, busy
   );
endinterface

// File: rtl/perceptron_seq_ctrl.sv
//------------------------------------------------------------------------------
// perceptron_seq_ctrl
//
// Sequencing controller for the digit-classifier perceptron. A frame of
// feature tokens is counted into saturating edge/curve counters. When the
// frame closes, the weighted sum (edges x 8, curves x 2) is built over two
// cycles, then the 10-entry class table is scanned one entry per cycle. The
// resulting digit is presented over a valid/ready handshake and held until
// the consumer takes it.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : perceptron_seq_ctrl_if.slave (token input, result output, status)
//
// Timing: last token accepted at edge N -> class_valid after edge N+3+k for
// a hit at table index k, after edge N+12 for a miss.
//------------------------------------------------------------------------------
module perceptron_seq_ctrl #(
   parameter int EDGE_W      = 3,
   parameter int CURVE_W     = 4,
   parameter int SUM_W       = 8,
   parameter int EDGE_SHIFT  = 3,
   parameter int CURVE_SHIFT = 1
) (
   input logic                 clk,
   input logic                 rst,
   perceptron_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_COLLECT = 3'd0,
      S_CALC_E  = 3'd1,
      S_CALC_C  = 3'd2,
      S_MATCH   = 3'd3,
      S_OUT     = 3'd4
   } state_t;

   localparam logic [1:0]         KIND_EDGE  = 2'b00;
   localparam logic [1:0]         KIND_CURVE = 2'b01;
   localparam logic [EDGE_W-1:0]  EDGE_MAX   = '1;
   localparam logic [CURVE_W-1:0] CURVE_MAX  = '1;
   localparam logic [3:0]         IDX_LAST   = 4'd9;
   localparam logic [3:0]         DIGIT_MISS = 4'hF;

   // Class table: index k is recognised when the frame's sum equals the
   // entry. Indices above 9 are never visited.
   function automatic logic [SUM_W-1:0] class_sum(input logic [3:0] i);
      logic [SUM_W-1:0] s;
      s = '0;
      case (i)
         4'd0:    s = SUM_W'(32);
         4'd1:    s = SUM_W'(2);
         4'd2:    s = SUM_W'(20);
         4'd3:    s = SUM_W'(34);
         4'd4:    s = SUM_W'(6);
         4'd5:    s = SUM_W'(28);
         4'd6:    s = SUM_W'(40);
         4'd7:    s = SUM_W'(4);
         4'd8:    s = SUM_W'(64);
         4'd9:    s = SUM_W'(26);
         default: s = '0;
      endcase
      return s;
   endfunction

   state_t             state_q,       state_d;
   logic [EDGE_W-1:0]  edge_cnt_q,    edge_cnt_d;
   logic [CURVE_W-1:0] curve_cnt_q,   curve_cnt_d;
   logic               overflow_q,    overflow_d;
   logic [SUM_W-1:0]   sum_q,         sum_d;
   logic [3:0]         idx_q,         idx_d;
   logic [3:0]         class_digit_q, class_digit_d;
   logic               class_hit_q,   class_hit_d;
   logic [SUM_W-1:0]   sum_out_q,     sum_out_d;

   logic               feat_accept;
   logic [SUM_W-1:0]   edge_ext;
   logic [SUM_W-1:0]   curve_ext;

   assign feat_accept = bus.feat_valid && (state_q == S_COLLECT);
   assign edge_ext    = SUM_W'(edge_cnt_q);
   assign curve_ext   = SUM_W'(curve_cnt_q);

   //---------------------------------------------------------------------------
   // Next-state and datapath
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so that paths
      // which do not assign it hold state instead of inferring a latch.
      state_d       = state_q;
      edge_cnt_d    = edge_cnt_q;
      curve_cnt_d   = curve_cnt_q;
      overflow_d    = overflow_q;
      sum_d         = sum_q;
      idx_d         = idx_q;
      class_digit_d = class_digit_q;
      class_hit_d   = class_hit_q;
      sum_out_d     = sum_out_q;

      case (state_q)
         S_COLLECT: begin
            if (feat_accept) begin
               // Saturating counts: an increment at max flags overflow
               // instead of wrapping. Marker and reserved tokens only
               // matter when they close the frame.
               if (bus.feat_kind == KIND_EDGE) begin
                  if (edge_cnt_q == EDGE_MAX) overflow_d = 1'b1;
                  else                        edge_cnt_d = edge_cnt_q + 1'b1;
               end else if (bus.feat_kind == KIND_CURVE) begin
                  if (curve_cnt_q == CURVE_MAX) overflow_d  = 1'b1;
                  else                          curve_cnt_d = curve_cnt_q + 1'b1;
               end
               if (bus.feat_last) state_d = S_CALC_E;
            end
         end

         S_CALC_E: begin
            sum_d   = edge_ext << EDGE_SHIFT;
            state_d = S_CALC_C;
         end

         S_CALC_C: begin
            // Maximum 56 + 30 = 86 fits SUM_W, so no wrap handling.
            sum_d   = sum_q + (curve_ext << CURVE_SHIFT);
            idx_d   = 4'd0;
            state_d = S_MATCH;
         end

         S_MATCH: begin
            // Scanning upward from 0 makes the first hit win.
            if (sum_q == class_sum(idx_q)) begin
               class_digit_d = idx_q;
               class_hit_d   = 1'b1;
               sum_out_d     = sum_q;
               state_d       = S_OUT;
            end else if (idx_q == IDX_LAST) begin
               class_digit_d = DIGIT_MISS;
               class_hit_d   = 1'b0;
               sum_out_d     = sum_q;
               state_d       = S_OUT;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end

         S_OUT: begin
            // Result registers hold until the consumer takes the result;
            // the frame state is cleared for the next frame on handshake.
            if (bus.class_ready) begin
               edge_cnt_d  = '0;
               curve_cnt_d = '0;
               overflow_d  = 1'b0;
               idx_d       = 4'd0;
               state_d     = S_COLLECT;
            end
         end

         default: state_d = S_COLLECT;
      endcase
   end

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_COLLECT;
         edge_cnt_q    <= '0;
         curve_cnt_q   <= '0;
         overflow_q    <= 1'b0;
         sum_q         <= '0;
         idx_q         <= 4'd0;
         class_digit_q <= 4'd0;
         class_hit_q   <= 1'b0;
         sum_out_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // computed before this edge, independent of statement order.
         state_q       <= state_d;
         edge_cnt_q    <= edge_cnt_d;
         curve_cnt_q   <= curve_cnt_d;
         overflow_q    <= overflow_d;
         sum_q         <= sum_d;
         idx_q         <= idx_d;
         class_digit_q <= class_digit_d;
         class_hit_q   <= class_hit_d;
         sum_out_q     <= sum_out_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign bus.feat_ready  = (state_q == S_COLLECT);
   assign bus.busy        = (state_q != S_COLLECT);
   assign bus.class_valid = (state_q == S_OUT);
   assign bus.class_digit = class_digit_q;
   assign bus.class_hit   = class_hit_q;
   assign bus.sum_out     = sum_out_q;
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_perceptron_seq_ctrl.sv
//------------------------------------------------------------------------------
// tb_perceptron_seq_ctrl
//
// Directed frames with hand-computed results. The stimulus process pushes the
// expected result of each frame into a scoreboard queue; the monitor process
// compares the DUT's result on every cycle it is presented and pops on the
// handshake. Inputs change on the falling edge; the monitor samples 1 ns
// after the falling edge.
//------------------------------------------------------------------------------
module tb_perceptron_seq_ctrl;

   typedef struct {
      logic [3:0] digit;
      logic       hit;
      logic [7:0] sum;
      logic       ovf;
      int         lat;
   } exp_t;

   logic clk;
   logic rst;

   perceptron_seq_ctrl_if #(.SUM_W(8)) bus ();

   perceptron_seq_ctrl #(
      .EDGE_W(3), .CURVE_W(4), .SUM_W(8), .EDGE_SHIFT(3), .CURVE_SHIFT(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   n_push = 0;
   int   n_pop  = 0;
   int   cyc    = 0;
   int   last_acc = 0;
   logic prev_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Offer one token (called at a falling edge); returns at the falling edge
   // after the accepting rising edge.
   task automatic send_tok(input logic [1:0] kind, input logic last);
      bit accepted;
      accepted = 1'b0;
      bus.feat_valid = 1'b1;
      bus.feat_kind  = kind;
      bus.feat_last  = last;
      for (int t = 0; t < 300; t++) begin
         if (bus.feat_ready) begin
            @(negedge clk);
            accepted = 1'b1;
            break;
         end
         @(negedge clk);
      end
      bus.feat_valid = 1'b0;
      bus.feat_last  = 1'b0;
      if (!accepted) check("accept_timeout", bus.feat_ready, 1);
   endtask

   task automatic send_n(input logic [1:0] kind, input int n, input logic last);
      for (int i = 0; i < n; i++) send_tok(kind, last && (i == n - 1));
   endtask

   task automatic expect_res(input logic [3:0] d, input logic h,
                             input logic [7:0] s, input logic o, input int lat);
      exp_t e;
      e.digit = d; e.hit = h; e.sum = s; e.ovf = o; e.lat = lat;
      sb.push_back(e);
      n_push++;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 300; t++) begin
         if (!bus.busy && !bus.class_valid) break;
         @(negedge clk);
      end
      check("idle_timeout", bus.busy, 0);
   endtask

   task automatic wait_valid();
      for (int t = 0; t < 300; t++) begin
         if (bus.class_valid) break;
         @(negedge clk);
      end
      check("valid_timeout", bus.class_valid, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_feat_ready"},  bus.feat_ready, 1);
      check({tag, "_class_valid"}, bus.class_valid, 0);
      check({tag, "_class_digit"}, bus.class_digit, 0);
      check({tag, "_class_hit"},   bus.class_hit, 0);
      check({tag, "_sum_out"},     bus.sum_out, 0);
      check({tag, "_overflow"},    bus.overflow, 0);
      check({tag, "_busy"},        bus.busy, 0);
   endtask

   // Monitor: compares every presented result against the scoreboard head.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.feat_valid && bus.feat_ready && bus.feat_last) last_acc = cyc + 1;
         if (bus.class_valid) begin
            if (sb.size() == 0) begin
               if (!prev_valid) check("spurious_valid", bus.class_valid, 0);
            end else begin
               if (!prev_valid) check("latency", cyc - last_acc, sb[0].lat);
               check("digit",      bus.class_digit, sb[0].digit);
               check("hit",        bus.class_hit,   sb[0].hit);
               check("sum_out",    bus.sum_out,     sb[0].sum);
               check("overflow",   bus.overflow,    sb[0].ovf);
               check("busy_out",   bus.busy,        1);
               check("ready_out",  bus.feat_ready,  0);
               if (bus.class_ready) begin
                  void'(sb.pop_front());
                  n_pop++;
               end
            end
         end
         prev_valid = bus.class_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst             = 1'b1;
      bus.feat_valid  = 1'b0;
      bus.feat_kind   = 2'b00;
      bus.feat_last   = 1'b0;
      bus.class_ready = 1'b1;
      #12;
      check_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 4 edges -> 32, digit 0 at idx 0
      expect_res(4'd0, 1'b1, 8'd32, 1'b0, 3);
      send_n(2'b00, 4, 1'b1);

      // 1 curve -> 2, digit 1
      expect_res(4'd1, 1'b1, 8'd2, 1'b0, 4);
      send_tok(2'b01, 1'b1);

      // 7 edges + 4 curves -> 64, digit 8
      expect_res(4'd8, 1'b1, 8'd64, 1'b0, 11);
      send_n(2'b00, 7, 1'b0);
      send_n(2'b01, 4, 1'b1);

      // 1 edge + 1 curve -> 10, miss
      expect_res(4'hF, 1'b0, 8'd10, 1'b0, 12);
      send_tok(2'b00, 1'b0);
      send_tok(2'b01, 1'b1);

      // marker-only frame -> 0, miss
      expect_res(4'hF, 1'b0, 8'd0, 1'b0, 12);
      send_tok(2'b10, 1'b1);

      // 9 edges saturate at 7 + 4 curves -> 64, overflow, under backpressure
      wait_idle();
      bus.class_ready = 1'b0;
      send_n(2'b00, 9, 1'b0);
      check("ovf_mid_frame", bus.overflow, 1);
      expect_res(4'd8, 1'b1, 8'd64, 1'b1, 11);
      send_n(2'b01, 4, 1'b1);
      wait_valid();
      for (int i = 0; i < 20; i++) begin
         bus.feat_valid = 1'b1;
         bus.feat_kind  = 2'b00;
         bus.feat_last  = 1'b1;
         @(negedge clk);
         check("bp_feat_ready", bus.feat_ready, 0);
         check("bp_valid_held", bus.class_valid, 1);
      end
      bus.feat_valid  = 1'b0;
      bus.feat_last   = 1'b0;
      bus.class_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", bus.class_valid, 0);
      check("bp_release_ready", bus.feat_ready, 1);
      check("bp_single_hs", n_pop, n_push);

      // Offered tokens were not counted and overflow is cleared: 1 curve -> 2
      expect_res(4'd1, 1'b1, 8'd2, 1'b0, 4);
      send_tok(2'b01, 1'b1);

      // Reserved and marker tokens are not counted -> 2, digit 1
      expect_res(4'd1, 1'b1, 8'd2, 1'b0, 4);
      send_tok(2'b01, 1'b0);
      send_tok(2'b11, 1'b0);
      send_tok(2'b10, 1'b0);
      send_tok(2'b11, 1'b1);

      // Reset during MATCH: 1 edge + 1 curve (miss path), abort at idx 5
      wait_idle();
      send_tok(2'b00, 1'b0);
      send_tok(2'b01, 1'b1);
      repeat (7) @(negedge clk);
      check("pre_rst_busy",  bus.busy, 1);
      check("pre_rst_valid", bus.class_valid, 0);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_match");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 2 curves -> 4, digit 7
      expect_res(4'd7, 1'b1, 8'd4, 1'b0, 10);
      send_n(2'b01, 2, 1'b1);

      for (int t = 0; t < 300; t++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      check("handshakes", n_pop, n_push);
      check("final_idle", bus.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
